imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port instruction memory between two requesters:
//  - the CPU fetch stage (read-only)
//  - the program loader (debug/boot read-write)
//  Sits between the fetch stage/loader and the instruction RAM. Provides
//  round-robin arbitration, a loader lock for program download, fetch
//  address checking, and a one-cycle registered read-response path.
// PARAMETERS
//  DEPTH    128          instruction RAM depth in 32-bit words
//  AW       $clog2(DEPTH) RAM word-address width
//  NOP_WORD 32'h00000000 instruction returned on a faulted fetch
// PORTS
//  clk       in  1   clock, all state on rising edge
//  reset     in  1   synchronous, active-high reset
//  f_req     in  1   fetch request
//  f_addr    in  32  fetch byte address (PC)
//  f_gnt     out 1   fetch request accepted this cycle
//  f_rvalid  out 1   fetch data valid (one cycle after f_gnt)
//  f_rdata   out 32  fetched instruction
//  f_err     out 1   qualifies f_rvalid: misaligned or out-of-range fetch
//  l_req     in  1   loader request
//  l_we      in  1   loader write enable (1 = write, 0 = read)
//  l_addr    in  32  loader byte address
//  l_wdata   in  32  loader write data
//  l_lock    in  1   loader owns memory exclusively while high
//  l_gnt     out 1   loader request accepted this cycle
//  l_rvalid  out 1   loader read data valid (one cycle after read l_gnt)
//  l_rdata   out 32  loader read data
//  ld_count  out 16  in-range loader writes since l_lock rose
//  cpu_stall out 1   high while fetch is held off by l_lock
//  m_en      out 1   RAM access enable
//  m_we      out 1   RAM write enable
//  m_addr    out AW  RAM word address (byte_addr >> 2)
//  m_wdata   out 32  RAM write data
//  m_rdata   in  32  RAM read data, valid the cycle after m_en && !m_we
// BEHAVIOUR
//  Reset: all outputs 0; rr_last = LOADER (fetch wins the first tie); the
//   pending-response registers are cleared, so any in-flight rvalid is dropped.
//  Grants: combinational, same cycle as req; at most one grant per cycle.
//   - l_lock=1: only the loader is granted; f_gnt=0; cpu_stall=f_req.
//   - l_lock=0, single requester: that requester is granted.
//   - l_lock=0, both requesting: the requester not in rr_last is granted;
//     rr_last updates on every grant.
//  Fetch check:
//   - Fault if f_addr[1:0]!=0 or f_addr>>2 >= DEPTH.
//   - A faulted fetch is still granted but m_en=0.
//   - Next cycle: f_rvalid=1, f_err=1, f_rdata=NOP_WORD.
//  Loader out-of-range (l_addr>>2 >= DEPTH):
//   - Granted; the write is dropped and ld_count is not incremented.
//   - A read returns l_rdata=0 with l_rvalid=1 next cycle.
//   - l_addr[1:0] is ignored (word aligned by truncation).
//  Latency: read data is registered; f_rvalid/l_rvalid are asserted exactly
//   1 cycle after the granting cycle; rdata holds its value until the next
//   rvalid. Writes produce no rvalid.
//  Lock FSM, states UNLOCKED -> LOCKED -> UNLOCKED:
//   - The rising edge of l_lock clears ld_count to 0 in that same cycle;
//     a write granted in that cycle counts as 1.
//   - ld_count saturates at 16'hFFFF and holds its value after unlock.
//  Lock asserted while a fetch read is in flight: that f_rvalid still
//   completes normally next cycle.
//  m_* outputs are 0 in any cycle with no granted in-range access.
// TESTING
//  1. Reset, f_req=1, f_addr=0x8, RAM[2]=0x2010000A -> f_gnt same cycle;
//     next cycle f_rvalid=1, f_rdata=0x2010000A, f_err=0.
//  2. f_req=l_req=1 (l_we=0) held for 4 cycles -> grants F,L,F,L;
//     rvalids follow one cycle later in the same order.
//  3. l_lock=1, 3 writes to 0x0/0x4/0x200 (DEPTH=128) -> ld_count=2;
//     RAM[0], RAM[1] updated; cpu_stall=1 while f_req=1.
//  4. f_addr=0x6 -> f_gnt=1, m_en=0; next cycle f_rvalid=1, f_err=1,
//     f_rdata=NOP_WORD.
//  5. reset asserted the cycle after a read grant -> no rvalid, ld_count=0.
//  6. Drop l_lock with f_req=1 -> f_gnt=1 the same cycle; cpu_stall=0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares a single-port instruction RAM between the CPU fetch stage and the program loader.
// Grants are combinational; read responses appear exactly one cycle after the grant.
module imem_port_arbiter #(
    parameter int          DEPTH    = 128,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic [15:0]   ld_count,
    output logic          cpu_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    typedef enum logic { UNLOCKED = 1'b0, LOCKED = 1'b1 } lock_state_e;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    lock_state_e state_q, state_d;
    logic        rr_last_q, rr_last_d;     // 1 = loader was granted last
    logic        f_pend_q, f_pend_d;
    logic        f_perr_q, f_perr_d;
    logic        l_pend_q, l_pend_d;
    logic        l_poor_q, l_poor_d;
    logic [31:0] f_hold_q, f_hold_d;
    logic [31:0] l_hold_q, l_hold_d;
    logic [15:0] ld_count_q, ld_count_d;

    logic        f_fault_s;
    logic        l_oor_s;
    logic        wr_cnt_s;
    logic [31:0] f_resp_s;
    logic [31:0] l_resp_s;

    assign f_fault_s = (f_addr[1:0] != 2'b00) || ((f_addr >> 2) >= DEPTH_W);
    assign l_oor_s   = (l_addr >> 2) >= DEPTH_W;
    assign wr_cnt_s  = l_gnt && l_we && !l_oor_s;
    assign f_resp_s  = f_perr_q ? NOP_WORD : m_rdata;
    assign l_resp_s  = l_poor_q ? 32'h0000_0000 : m_rdata;

    // Arbitration: lock gives the loader exclusive access, otherwise round-robin on ties
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset) begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end else if (l_lock) begin
            l_gnt = l_req;
        end else if (f_req && l_req) begin
            f_gnt = rr_last_q;
            l_gnt = !rr_last_q;
        end else begin
            f_gnt = f_req;
            l_gnt = l_req;
        end
    end

    // RAM-side drive; faulted fetches and out-of-range loader accesses never reach the RAM
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = 32'h0000_0000;
        if (f_gnt && !f_fault_s) begin
            m_en   = 1'b1;
            m_addr = f_addr[AW+1:2];
        end else if (l_gnt && !l_oor_s) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = l_addr[AW+1:2];
            m_wdata = l_we ? l_wdata : 32'h0000_0000;
        end else begin
            m_en = 1'b0;
        end
    end

    // Response outputs; data follows the RAM in the rvalid cycle and holds afterwards
    always_comb begin
        f_rvalid  = f_pend_q && !reset;
        f_err     = f_pend_q && f_perr_q && !reset;
        l_rvalid  = l_pend_q && !reset;
        cpu_stall = l_lock && f_req && !reset;
        ld_count  = reset ? 16'h0000 : ld_count_q;
        if (reset) begin
            f_rdata = 32'h0000_0000;
            l_rdata = 32'h0000_0000;
        end else begin
            f_rdata = f_pend_q ? f_resp_s : f_hold_q;
            l_rdata = l_pend_q ? l_resp_s : l_hold_q;
        end
    end

    // Next-state for arbitration history, pending responses and held read data
    always_comb begin
        rr_last_d = rr_last_q;
        if (f_gnt) begin
            rr_last_d = 1'b0;
        end else if (l_gnt) begin
            rr_last_d = 1'b1;
        end else begin
            rr_last_d = rr_last_q;
        end
        f_pend_d = f_gnt;
        f_perr_d = f_gnt && f_fault_s;
        l_pend_d = l_gnt && !l_we;
        l_poor_d = l_gnt && !l_we && l_oor_s;
        f_hold_d = f_pend_q ? f_resp_s : f_hold_q;
        l_hold_d = l_pend_q ? l_resp_s : l_hold_q;
    end

    // Lock FSM: the lock rising edge restarts the in-range write count
    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        case (state_q)
            UNLOCKED: begin
                if (l_lock) begin
                    state_d    = LOCKED;
                    ld_count_d = wr_cnt_s ? 16'h0001 : 16'h0000;
                end else begin
                    state_d = UNLOCKED;
                end
            end
            LOCKED: begin
                if (!l_lock) begin
                    state_d = UNLOCKED;
                end else if (wr_cnt_s && (ld_count_q != 16'hFFFF)) begin
                    ld_count_d = ld_count_q + 16'h0001;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                ld_count_d = ld_count_q;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            rr_last_q  <= 1'b1;
            f_pend_q   <= 1'b0;
            f_perr_q   <= 1'b0;
            l_pend_q   <= 1'b0;
            l_poor_q   <= 1'b0;
            f_hold_q   <= 32'h0000_0000;
            l_hold_q   <= 32'h0000_0000;
            ld_count_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            f_pend_q   <= f_pend_d;
            f_perr_q   <= f_perr_d;
            l_pend_q   <= l_pend_d;
            l_poor_q   <= l_poor_d;
            f_hold_q   <= f_hold_d;
            l_hold_q   <= l_hold_d;
            ld_count_q <= ld_count_d;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural single-port RAM attached.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid, cpu_stall;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic [15:0] ld_count;
    logic        m_en, m_we;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [31:0] ram [0:127];

    int tests = 0;
    int fails = 0;

    imem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .ld_count(ld_count), .cpu_stall(cpu_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model, preloaded while reset is held
    always @(posedge clk) begin
        if (reset) begin
            ram[0] <= 32'h1111_1111;
            ram[1] <= 32'h2222_2222;
            ram[2] <= 32'h2010_000A;
            ram[3] <= 32'h3333_3333;
        end else if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata     <= ram[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cy();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
        l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;
        cy(); cy();
        f_req = 1'b1; l_req = 1'b1;
        #2;
        chk("rst_f_gnt",    32'(f_gnt),    32'd0);
        chk("rst_l_gnt",    32'(l_gnt),    32'd0);
        chk("rst_m_en",     32'(m_en),     32'd0);
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);

        // Single fetch of word 2
        cy(); reset = 1'b0; l_req = 1'b0; f_addr = 32'h8;
        #2;
        chk("t1_f_gnt",  32'(f_gnt),  32'd1);
        chk("t1_l_gnt",  32'(l_gnt),  32'd0);
        chk("t1_m_en",   32'(m_en),   32'd1);
        chk("t1_m_addr", 32'(m_addr), 32'd2);
        cy(); f_req = 1'b0;
        #2;
        chk("t1_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("t1_f_rdata",  f_rdata,       32'h2010_000A);
        chk("t1_f_err",    32'(f_err),    32'd0);
        cy();
        #2;
        chk("t1_rvalid_off", 32'(f_rvalid), 32'd0);
        chk("t1_rdata_hold", f_rdata,       32'h2010_000A);

        // Loader read with unaligned address truncates to word 3
        l_req = 1'b1; l_addr = 32'hE;
        #2;
        chk("lr_l_gnt",  32'(l_gnt),  32'd1);
        chk("lr_m_addr", 32'(m_addr), 32'd3);
        cy(); l_req = 1'b0;
        #2;
        chk("lr_l_rvalid", 32'(l_rvalid), 32'd1);
        chk("lr_l_rdata",  l_rdata,       32'h3333_3333);

        // Both requesting: alternating grants, fetch first since loader was last
        cy(); f_req = 1'b1; l_req = 1'b1; f_addr = 32'h0; l_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rr_f_gnt", 32'(f_gnt), 32'(i % 2 == 0));
            chk("rr_l_gnt", 32'(l_gnt), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("rr_f_rvalid", 32'(f_rvalid), 32'(i % 2 == 1));
                chk("rr_l_rvalid", 32'(l_rvalid), 32'(i % 2 == 0));
            end
            cy();
        end
        f_req = 1'b0; l_req = 1'b0;
        #2;
        chk("rr_last_l_rvalid", 32'(l_rvalid), 32'd1);
        chk("rr_last_l_rdata",  l_rdata,       32'h2222_2222);
        chk("rr_f_rdata_hold",  f_rdata,       32'h1111_1111);

        // Locked download: two in-range writes and one out-of-range
        cy(); l_lock = 1'b1; l_req = 1'b1; l_we = 1'b1; f_req = 1'b1;
        l_addr = 32'h0; l_wdata = 32'hAAAA_0000;
        #2;
        chk("lk_f_gnt",     32'(f_gnt),     32'd0);
        chk("lk_l_gnt",     32'(l_gnt),     32'd1);
        chk("lk_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("lk_m_we",      32'(m_we),      32'd1);
        chk("lk_m_wdata",   m_wdata,        32'hAAAA_0000);
        cy(); l_addr = 32'h4; l_wdata = 32'hBBBB_0001;
        #2;
        chk("lk_count1", 32'(ld_count), 32'd1);
        cy(); l_addr = 32'h200; l_wdata = 32'hDEAD_BEEF;
        #2;
        chk("lk_oor_gnt",  32'(l_gnt),    32'd1);
        chk("lk_oor_m_en", 32'(m_en),     32'd0);
        chk("lk_count2",   32'(ld_count), 32'd2);
        cy(); l_we = 1'b0; l_addr = 32'h0;
        #2;
        chk("lk_count_oor", 32'(ld_count),  32'd2);
        chk("lk_stall2",    32'(cpu_stall), 32'd1);
        chk("lk_ram0",      ram[0],         32'hAAAA_0000);
        chk("lk_ram1",      ram[1],         32'hBBBB_0001);
        cy(); l_addr = 32'h200;
        #2;
        chk("lk_rd_rvalid", 32'(l_rvalid), 32'd1);
        chk("lk_rd_rdata",  l_rdata,       32'hAAAA_0000);
        cy(); l_req = 1'b0;
        #2;
        chk("lk_oor_rvalid", 32'(l_rvalid), 32'd1);
        chk("lk_oor_rdata",  l_rdata,       32'h0000_0000);

        // Unlock with fetch pending: granted at once
        cy(); l_lock = 1'b0; f_addr = 32'h4;
        #2;
        chk("ul_f_gnt", 32'(f_gnt),     32'd1);
        chk("ul_stall", 32'(cpu_stall), 32'd0);
        cy(); f_addr = 32'h6;
        #2;
        chk("ul_f_rdata",   f_rdata,        32'hBBBB_0001);
        chk("ul_count_hold", 32'(ld_count), 32'd2);
        chk("mis_f_gnt",    32'(f_gnt),     32'd1);
        chk("mis_m_en",     32'(m_en),      32'd0);
        cy(); f_addr = 32'h1FC;
        #2;
        chk("mis_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("mis_f_err",    32'(f_err),    32'd1);
        chk("mis_f_rdata",  f_rdata,       32'h0000_0000);
        chk("top_m_en",     32'(m_en),     32'd1);
        chk("top_m_addr",   32'(m_addr),   32'd127);
        cy(); f_addr = 32'h200;
        #2;
        chk("top_f_err",  32'(f_err), 32'd0);
        chk("oor_m_en",   32'(m_en),  32'd0);
        cy(); f_addr = 32'h8;
        #2;
        chk("oor_f_err", 32'(f_err), 32'd1);

        // Lock rises while a fetch read is in flight
        cy(); l_lock = 1'b1;
        #2;
        chk("if_f_gnt",    32'(f_gnt),    32'd0);
        chk("if_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("if_f_rdata",  f_rdata,       32'h2010_000A);
        chk("if_f_err",    32'(f_err),    32'd0);
        cy(); f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'h5555_5555;
        #2;
        chk("if_count_clr", 32'(ld_count), 32'd0);
        chk("if_l_gnt",     32'(l_gnt),    32'd1);
        cy(); l_req = 1'b0; l_lock = 1'b0;
        #2;
        chk("if_count1", 32'(ld_count), 32'd1);

        // Reset the cycle after a loader read grant drops the response
        cy(); l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8;
        #2;
        chk("rs_l_gnt", 32'(l_gnt), 32'd1);
        cy(); reset = 1'b1; l_req = 1'b0;
        #2;
        chk("rs_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rs_count",    32'(ld_count), 32'd0);
        cy(); reset = 1'b0;
        #2;
        chk("rs_l_rvalid2", 32'(l_rvalid), 32'd0);
        chk("rs_count2",    32'(ld_count), 32'd0);

        // After reset the fetch side wins the first tie
        f_req = 1'b1; l_req = 1'b1; f_addr = 32'h0; l_addr = 32'h0;
        #2;
        chk("pr_f_gnt", 32'(f_gnt), 32'd1);
        chk("pr_l_gnt", 32'(l_gnt), 32'd0);
        cy();
        #2;
        chk("pr_l_gnt2", 32'(l_gnt), 32'd1);
        cy(); f_req = 1'b0; l_req = 1'b0;
        cy();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
